// File: rtl/imm_extend_unit.sv
// imm_extend_unit: immediate extender (zero/sign/upper/branch) feeding a 2-entry valid/ready output buffer.
// Optional macro IMM_EXT_STATS_EN adds the ext_count port counting completed output transfers.
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [31:0]      ext_count
`endif
);
    localparam int EXT_W = OUT_W - IN_W;
    generate
        if (IN_W < 1 || OUT_W < IN_W + 2) begin : g_bad_params
            $error("imm_extend_unit: requires IN_W >= 1 and OUT_W >= IN_W + 2");
        end
    endgenerate
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] data_q [2];
    logic [1:0]       mode_q [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    // Extend the incoming immediate according to its mode before it enters the buffer
    always_comb begin
        sext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        ext  = in_mode == 2'b00 ? {{EXT_W{1'b0}}, in_imm} :
               in_mode == 2'b01 ? sext :
               in_mode == 2'b10 ? {in_imm, {EXT_W{1'b0}}} :
                                  {sext[OUT_W-3:0], 2'b00};
    end
    // Handshake flags come only from registered occupancy so in_ready never follows out_ready
    always_comb begin
        in_ready  = count != 2'd2;
        out_valid = count != 2'd0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = data_q[head];
        out_mode  = mode_q[head];
    end
    // Buffer storage and pointers; popped entries are left in place, count alone gates visibility
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 2'd0;
            head      <= 1'b0;
            tail      <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            mode_q[0] <= 2'b00;
            mode_q[1] <= 2'b00;
        end else begin
            if (push) begin
                data_q[tail] <= ext;
                mode_q[tail] <= in_mode;
                tail         <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
`ifdef IMM_EXT_STATS_EN
    // Saturating count of completed output transfers
    always_ff @(posedge clk) begin
        if (reset) ext_count <= '0;
        else if (pop && ext_count != '1) ext_count <= ext_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed self-checking bench for imm_extend_unit (IMM_EXT_STATS_EN optional).
module tb_imm_extend_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
`ifdef IMM_EXT_STATS_EN
    logic [31:0] ext_count;
`endif
    int n_cmp = 0;
    int n_err = 0;

    imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
`ifdef IMM_EXT_STATS_EN
        , .ext_count(ext_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] m);
        in_valid = v;
        in_imm   = imm;
        in_mode  = m;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 2'b00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_cmp++; if (out_mode !== 2'b00) begin n_err++; $display("FAIL reset_out_mode: got %b expected 00", out_mode); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    endtask

    task automatic test_zero_sign;
        out_ready = 1'b1;
        drive(1'b1, 16'h8001, 2'b00);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00008001) begin n_err++; $display("FAIL zero_ext: got valid=%b data=%h expected valid=1 data=00008001", out_valid, out_data); end
        drive(1'b1, 16'h8001, 2'b01);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF8001 || out_mode !== 2'b01) begin n_err++; $display("FAIL sign_ext: got valid=%b data=%h mode=%b expected valid=1 data=ffff8001 mode=01", out_valid, out_data, out_mode); end
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_modes;
        logic [15:0] imm [6] = '{16'h1234, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0001, 16'h8000};
        logic [1:0]  md  [6] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11};
        logic [31:0] exp [6] = '{32'h12340000, 32'hFFFFFFF8, 32'h0001FFFC, 32'hFFFF8000, 32'h00010000, 32'hFFFE0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, imm[i], md[i]);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_mode !== md[i]) begin n_err++; $display("FAIL mode_vec%0d: got valid=%b data=%h mode=%b expected valid=1 data=%h mode=%b", i, out_valid, out_data, out_mode, exp[i], md[i]); end
        end
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        drive(1'b1, 16'h000A, 2'b00);
        @(negedge clk);
        n_cmp++; if (out_data !== 32'hA || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_first: got data=%h ready=%b expected data=0000000a ready=1", out_data, in_ready); end
        drive(1'b1, 16'h000B, 2'b00);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0 || out_data !== 32'hA) begin n_err++; $display("FAIL stall_full: got ready=%b data=%h expected ready=0 data=0000000a", in_ready, out_data); end
        drive(1'b1, 16'h000C, 2'b00);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin n_err++; $display("FAIL stall_hold: got ready=%b valid=%b data=%h expected ready=0 valid=1 data=0000000a", in_ready, out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_data !== 32'hB || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_second: got data=%h ready=%b expected data=0000000b ready=1", out_data, in_ready); end
        @(negedge clk);
        drive(1'b0, 16'h0, 2'b00);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hC) begin n_err++; $display("FAIL stall_third: got valid=%b data=%h expected valid=1 data=0000000c", out_valid, out_data); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_dup: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] imm [9] = '{16'h00F0, 16'h80F0, 16'hABCD, 16'h4000, 16'hC000, 16'h7FFF, 16'h0000, 16'h8001, 16'hFFFF};
        logic [1:0]  md  [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        logic [31:0] exp [9] = '{32'h000000F0, 32'hFFFF80F0, 32'hABCD0000, 32'h00010000, 32'h0000C000,
                                 32'h00007FFF, 32'h00000000, 32'hFFFE0004, 32'hFFFFFFFF};
        out_ready = 1'b0;
        drive(1'b1, imm[0], md[0]);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            drive(1'b1, imm[i], md[i]);
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== exp[i-1] || out_mode !== md[i-1]) begin n_err++; $display("FAIL b2b_%0d: got valid=%b ready=%b data=%h mode=%b expected valid=1 ready=1 data=%h mode=%b", i-1, out_valid, in_ready, out_data, out_mode, exp[i-1], md[i-1]); end
            @(negedge clk);
        end
        drive(1'b0, 16'h0, 2'b00);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp[8]) begin n_err++; $display("FAIL b2b_8: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, exp[8]); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_flush;
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 2'b01);
        @(negedge clk);
        drive(1'b1, 16'h2222, 2'b10);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full: got ready=%b expected 0", in_ready); end
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h3333, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 16'h0, 2'b00);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_mode !== 2'b00) begin n_err++; $display("FAIL flush_state: got valid=%b ready=%b data=%h mode=%b expected valid=0 ready=1 data=00000000 mode=00", out_valid, in_ready, out_data, out_mode); end
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost: got valid=%b expected 0", out_valid); end
    endtask

`ifdef IMM_EXT_STATS_EN
    task automatic test_stats;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (ext_count !== 32'd0) begin n_err++; $display("FAIL stats_clear: got %0d expected 0", ext_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(i), 2'b00);
            @(negedge clk);
        end
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        n_cmp++; if (ext_count !== 32'd5) begin n_err++; $display("FAIL stats_five: got %0d expected 5", ext_count); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (ext_count !== 32'd0) begin n_err++; $display("FAIL stats_reset: got %0d expected 0", ext_count); end
    endtask
`endif

    initial begin
        test_reset;
        test_zero_sign;
        test_modes;
        test_stall;
        test_back_to_back;
        test_reset_flush;
`ifdef IMM_EXT_STATS_EN
        test_stats;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
